// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; a byte written to an idle block starts on the line one edge later.
// Back-to-back frames chain with no idle gap; writes while full are dropped.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clkM,
  input  logic       rstM,
  input  logic [7:0] dataM,
  input  logic       wrM,
  output logic       txM,
  output logic       fullM,
  output logic       emptyM,
  output logic       busyM,
  output logic       doneM
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt, done_nxt, pop, push;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count, count_nxt;

  // fullM is the registered flag, so a pop on the same edge cannot rescue a write
  assign push  = wrM && !fullM;
  assign busyM = (state != IDLE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clkM or negedge rstM) begin
    if (!rstM) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fullM  <= 1'b0;
      emptyM <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      fullM  <= (count_nxt == DEPTH_CNT);
      emptyM <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clkM) begin
    if (push) mem[wr_ptr] <= dataM;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    tx_nxt    = txM;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!emptyM) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
          cnt_nxt   = '0;
          tx_nxt    = shift[0];
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
            tx_nxt  = shift[idx + 3'd1];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          done_nxt = 1'b1;
          cnt_nxt  = '0;
          // chain straight into the next start bit when more data is waiting
          if (!emptyM) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clkM or negedge rstM) begin
    if (!rstM) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txM   <= 1'b1;
      doneM <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
      txM   <= tx_nxt;
      doneM <= done_nxt;
    end
  end
endmodule
